// File: rtl/exu_result_stage_pkg.sv
// Shared execute-lane types: branch kinds and the writeback payload.
package srv_defs;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        NONE, BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR
    } br_type_t;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic [4:0]      rd;
        logic            we;
    } exu_out_t;

endpackage

// File: rtl/exu_result_stage_skid_buffer.sv
// Two-entry skid buffer, generic payload. in_ready comes straight from a flop,
// so downstream back-pressure never reaches the producer combinationally.
module skid_buffer #(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic main_valid, skid_valid;
    T     main_data, skid_data;
    logic accept, drain;

    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & ~skid_valid & ~flush;
    assign drain     = main_valid & out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (drain) begin
            // skid and accept are exclusive: accept needs skid empty
            if (skid_valid) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data  <= in_data;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end
        end
    end

endmodule

// File: rtl/exu_result_stage.sv
// Execute-lane result stage: branch resolution, registered redirect, skid-buffered
// writeback. Define SRV_BRANCH_STATS_EN to build the saturating branch counters.
module exu_result_stage
    import srv_defs::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     alu_res,
    input  logic            alu_eq,
    input  logic            alu_lt,
    input  br_type_t        br_type,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] br_target,
    input  logic            pred_taken,
    input  logic [4:0]      rd,
    input  logic            rd_we,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_res,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    logic            taken, is_jump, accept, mispredict;
    logic [PC_W-1:0] link, target;
    exu_out_t        wb_in, wb_out;

    always_comb begin
        taken = 1'b0;
        case (br_type)
            BEQ:       taken = alu_eq;
            BNE:       taken = ~alu_eq;
            BLT, BLTU: taken = alu_lt;
            BGE, BGEU: taken = ~alu_lt;
            JAL, JALR: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

    assign is_jump    = (br_type == JAL) || (br_type == JALR);
    assign link       = pc + PC_W'(4);
    assign target     = (br_type == JALR) ? PC_W'({alu_res[31:1], 1'b0}) : br_target;
    assign accept     = in_valid & in_ready & ~flush;
    assign mispredict = accept & (br_type != NONE) & (taken != pred_taken);

    assign wb_in.res = is_jump ? 32'(link) : alu_res;
    assign wb_in.rd  = rd;
    assign wb_in.we  = rd_we;

    skid_buffer #(.T(exu_out_t)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (wb_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (wb_out)
    );

    assign out_res = wb_out.res;
    assign out_rd  = wb_out.rd;
    assign out_we  = wb_out.we;

    // Redirect ignores writeback stalls; it fires on acceptance, not on drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= mispredict;
            if (mispredict)
                redirect_pc <= taken ? target : link;
        end
    end

`ifdef SRV_BRANCH_STATS_EN
    logic [31:0] n_br, n_mp;

    always_ff @(posedge clk) begin
        if (rst) begin
            n_br <= '0;
            n_mp <= '0;
        end else begin
            if (accept && br_type != NONE && n_br != 32'hFFFF_FFFF)
                n_br <= n_br + 32'd1;
            if (mispredict && n_mp != 32'hFFFF_FFFF)
                n_mp <= n_mp + 32'd1;
        end
    end

    assign stat_branches    = n_br;
    assign stat_mispredicts = n_mp;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule
